// File: rtl/rv32i_inst_encoder_pkg.sv
// Shared types, RV32I opcode/funct constants and field-packing helpers
// used by the instruction encoder.
package enc_pkg;

  // Symbolic instruction requests: the 37 base RV32I ops plus pseudo-ops.
  typedef enum logic [5:0] {
    OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3,
    OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7,
    OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9,  OP_LB    = 6'd10, OP_LH    = 6'd11,
    OP_LW    = 6'd12, OP_LBU   = 6'd13, OP_LHU   = 6'd14, OP_SB    = 6'd15,
    OP_SH    = 6'd16, OP_SW    = 6'd17, OP_ADDI  = 6'd18, OP_SLTI  = 6'd19,
    OP_SLTIU = 6'd20, OP_XORI  = 6'd21, OP_ORI   = 6'd22, OP_ANDI  = 6'd23,
    OP_SLLI  = 6'd24, OP_SRLI  = 6'd25, OP_SRAI  = 6'd26, OP_ADD   = 6'd27,
    OP_SUB   = 6'd28, OP_SLL   = 6'd29, OP_SLT   = 6'd30, OP_SLTU  = 6'd31,
    OP_XOR   = 6'd32, OP_SRL   = 6'd33, OP_SRA   = 6'd34, OP_OR    = 6'd35,
    OP_AND   = 6'd36, OP_NOP   = 6'd37, OP_LI    = 6'd38, OP_J     = 6'd39
  } enc_op_t;

  // Encoder sequencing: LI2 holds the second half of a two-word LI.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } enc_state_t;

  // Major opcodes, same values as the decoder uses.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  // Load/store funct3
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7: ALT selects SUB/SRA(I)
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  // imm_h carries byte-offset bits [12:1]; bit 0 never reaches the word.
  function automatic logic [31:0] pack_b(input logic [12:1] imm_h, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm_h[12], imm_h[10:5], rs2, rs1, f3, imm_h[4:1], imm_h[11], opc};
  endfunction

  function automatic logic [31:0] pack_u(input logic [19:0] imm_hi, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm_hi, rd, opc};
  endfunction

  // imm_h carries byte-offset bits [20:1].
  function automatic logic [31:0] pack_j(input logic [20:1] imm_h, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm_h[20], imm_h[10:1], imm_h[11], imm_h[19:12], rd, opc};
  endfunction

endpackage

// File: rtl/rv32i_enc_comb.sv
// Combinational encoder: symbolic op + operands -> RV32I word. For LI it
// also produces the follow-up ADDI word and flags the two-word case.
module rv32i_enc_comb
  import enc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic [31:0] inst_lo,
  output logic        two_word,
  output logic        illegal
);

  logic        li_small;
  logic [19:0] li_hi;

  // LI fits ADDI when bits [31:11] are pure sign extension; otherwise the
  // upper part is rounded up when the low 12 bits will be negative.
  always_comb begin
    li_small = (imm[31:11] == {21{imm[11]}});
    li_hi    = imm[31:12] + {19'd0, imm[11]};
  end

  // Map the requested op onto its encoding group.
  always_comb begin
    inst     = 32'd0;
    inst_lo  = 32'd0;
    two_word = 1'b0;
    illegal  = 1'b0;
    case (op)
      OP_LUI:   inst = pack_u(imm[31:12], rd, OPC_LUI);
      OP_AUIPC: inst = pack_u(imm[31:12], rd, OPC_AUIPC);
      OP_JAL:   inst = pack_j(imm[20:1], rd, OPC_JAL);
      OP_J:     inst = pack_j(imm[20:1], 5'd0, OPC_JAL);
      OP_JALR:  inst = pack_i(imm[11:0], rs1, F3_JALR, rd, OPC_JALR);
      OP_BEQ:   inst = pack_b(imm[12:1], rs2, rs1, F3_BEQ,  OPC_BRANCH);
      OP_BNE:   inst = pack_b(imm[12:1], rs2, rs1, F3_BNE,  OPC_BRANCH);
      OP_BLT:   inst = pack_b(imm[12:1], rs2, rs1, F3_BLT,  OPC_BRANCH);
      OP_BGE:   inst = pack_b(imm[12:1], rs2, rs1, F3_BGE,  OPC_BRANCH);
      OP_BLTU:  inst = pack_b(imm[12:1], rs2, rs1, F3_BLTU, OPC_BRANCH);
      OP_BGEU:  inst = pack_b(imm[12:1], rs2, rs1, F3_BGEU, OPC_BRANCH);
      OP_LB:    inst = pack_i(imm[11:0], rs1, F3_B,  rd, OPC_LOAD);
      OP_LH:    inst = pack_i(imm[11:0], rs1, F3_H,  rd, OPC_LOAD);
      OP_LW:    inst = pack_i(imm[11:0], rs1, F3_W,  rd, OPC_LOAD);
      OP_LBU:   inst = pack_i(imm[11:0], rs1, F3_BU, rd, OPC_LOAD);
      OP_LHU:   inst = pack_i(imm[11:0], rs1, F3_HU, rd, OPC_LOAD);
      OP_SB:    inst = pack_s(imm[11:0], rs2, rs1, F3_B, OPC_STORE);
      OP_SH:    inst = pack_s(imm[11:0], rs2, rs1, F3_H, OPC_STORE);
      OP_SW:    inst = pack_s(imm[11:0], rs2, rs1, F3_W, OPC_STORE);
      OP_ADDI:  inst = pack_i(imm[11:0], rs1, F3_ADD,  rd, OPC_OP_IMM);
      OP_SLTI:  inst = pack_i(imm[11:0], rs1, F3_SLT,  rd, OPC_OP_IMM);
      OP_SLTIU: inst = pack_i(imm[11:0], rs1, F3_SLTU, rd, OPC_OP_IMM);
      OP_XORI:  inst = pack_i(imm[11:0], rs1, F3_XOR,  rd, OPC_OP_IMM);
      OP_ORI:   inst = pack_i(imm[11:0], rs1, F3_OR,   rd, OPC_OP_IMM);
      OP_ANDI:  inst = pack_i(imm[11:0], rs1, F3_AND,  rd, OPC_OP_IMM);
      OP_SLLI:  inst = pack_i({F7_BASE, imm[4:0]}, rs1, F3_SLL, rd, OPC_OP_IMM);
      OP_SRLI:  inst = pack_i({F7_BASE, imm[4:0]}, rs1, F3_SR,  rd, OPC_OP_IMM);
      OP_SRAI:  inst = pack_i({F7_ALT,  imm[4:0]}, rs1, F3_SR,  rd, OPC_OP_IMM);
      OP_ADD:   inst = pack_r(F7_BASE, rs2, rs1, F3_ADD,  rd, OPC_OP);
      OP_SUB:   inst = pack_r(F7_ALT,  rs2, rs1, F3_ADD,  rd, OPC_OP);
      OP_SLL:   inst = pack_r(F7_BASE, rs2, rs1, F3_SLL,  rd, OPC_OP);
      OP_SLT:   inst = pack_r(F7_BASE, rs2, rs1, F3_SLT,  rd, OPC_OP);
      OP_SLTU:  inst = pack_r(F7_BASE, rs2, rs1, F3_SLTU, rd, OPC_OP);
      OP_XOR:   inst = pack_r(F7_BASE, rs2, rs1, F3_XOR,  rd, OPC_OP);
      OP_SRL:   inst = pack_r(F7_BASE, rs2, rs1, F3_SR,   rd, OPC_OP);
      OP_SRA:   inst = pack_r(F7_ALT,  rs2, rs1, F3_SR,   rd, OPC_OP);
      OP_OR:    inst = pack_r(F7_BASE, rs2, rs1, F3_OR,   rd, OPC_OP);
      OP_AND:   inst = pack_r(F7_BASE, rs2, rs1, F3_AND,  rd, OPC_OP);
      OP_NOP:   inst = pack_i(12'd0, 5'd0, F3_ADD, 5'd0, OPC_OP_IMM);
      OP_LI: begin
        if (li_small) begin
          inst = pack_i(imm[11:0], 5'd0, F3_ADD, rd, OPC_OP_IMM);
        end else begin
          inst     = pack_u(li_hi, rd, OPC_LUI);
          inst_lo  = pack_i(imm[11:0], rd, F3_ADD, rd, OPC_OP_IMM);
          two_word = 1'b1;
        end
      end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// Instruction encoder top: request handshake, LI expansion sequencing,
// single-entry output register and IROM address counter.
module rv32i_inst_encoder
  import enc_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  enc_state_t        state_reg, state_next;
  logic              out_valid_reg, out_valid_next;
  logic [31:0]       out_inst_reg, out_inst_next;
  logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [31:0]       lo_reg, lo_next;
  logic              err_reg, err_next;

  logic [31:0] enc_inst;
  logic [31:0] enc_inst_lo;
  logic        enc_two_word;
  logic        enc_illegal;
  logic        drain;
  logic        accept;

  rv32i_enc_comb u_enc (
    .op       (req_op),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (req_imm),
    .inst     (enc_inst),
    .inst_lo  (enc_inst_lo),
    .two_word (enc_two_word),
    .illegal  (enc_illegal)
  );

  assign req_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign drain     = out_valid_reg && out_ready;
  assign accept    = req_valid && req_ready;

  // Next-state, output-register loading and address counter update.
  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_inst_next  = out_inst_reg;
    out_addr_next  = out_addr_reg;
    lo_next        = lo_reg;
    err_next       = err_reg;

    // A clear wins over a same-cycle drain: the drained word belonged to
    // the old sequence, and whatever is loaded now starts the new one.
    if ((state_reg == ST_IDLE) && addr_clr) begin
      cnt_next = BASE_ADDR;
    end else if (drain) begin
      cnt_next = cnt_reg + ADDR_W'(4);
    end else begin
      cnt_next = cnt_reg;
    end

    if (drain) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (enc_illegal) begin
            err_next = 1'b1;
          end else begin
            out_valid_next = 1'b1;
            out_inst_next  = enc_inst;
            out_addr_next  = cnt_next;
            if (enc_two_word) begin
              lo_next    = enc_inst_lo;
              state_next = ST_LI2;
            end
          end
        end
      end
      ST_LI2: begin
        if (drain) begin
          out_valid_next = 1'b1;
          out_inst_next  = lo_reg;
          out_addr_next  = cnt_next;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial expansion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      out_inst_reg  <= 32'd0;
      out_addr_reg  <= BASE_ADDR;
      cnt_reg       <= BASE_ADDR;
      lo_reg        <= 32'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      out_inst_reg  <= out_inst_next;
      out_addr_reg  <= out_addr_next;
      cnt_reg       <= cnt_next;
      lo_reg        <= lo_next;
      err_reg       <= err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_inst  = out_inst_reg;
  assign out_addr  = out_addr_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder with hand-computed encodings.
module tb_rv32i_inst_encoder;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_clr;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [15:0] out_addr;
  logic        err;

  int n_total = 0;
  int n_bad   = 0;

  rv32i_inst_encoder #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_clr  (addr_clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one request at a negedge; it must be accepted at the next edge.
  task automatic issue(input string tag, input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    tick();
  endtask

  task automatic word(input string tag, input logic [31:0] inst, input logic [15:0] addr);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inst"}, out_inst, inst);
    chk({tag, "_addr"}, {16'd0, out_addr}, {16'd0, addr});
    $display("word %s: inst=0x%08h addr=0x%04h", tag, out_inst, out_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; addr_clr = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_op = 6'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_vld",  {31'd0, out_valid}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    // ADDI x1,x0,5: word appears exactly one edge after acceptance
    chk("pre_addi_vld", {31'd0, out_valid}, 32'd0);
    issue("addi", OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    req_valid = 1'b0;
    word("addi", 32'h00500093, 16'h0000);
    tick();
    chk("addi_drain_vld", {31'd0, out_valid}, 32'd0);
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;

    // Two-word LI with rounding of the upper part
    issue("li_big", OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    req_valid = 1'b0;
    word("li_lui", 32'h123462B7, 16'h0000);
    chk("li2_rdy", {31'd0, req_ready}, 32'd0);
    tick();
    word("li_addi", 32'hFFF28293, 16'h0004);
    chk("li_idle_rdy", {31'd0, req_ready}, 32'd1);

    // Back-to-back with addr_clr on the accepting cycle
    addr_clr = 1'b1;
    issue("li100", OP_LI, 5'd5, 5'd0, 5'd0, 32'd100);
    addr_clr = 1'b0;
    word("li100", 32'h06400293, 16'h0000);
    issue("beq", OP_BEQ, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    word("beq", 32'hFE208EE3, 16'h0004);

    // Backpressure: word held stable, no new request taken
    issue("srai", OP_SRAI, 5'd3, 5'd3, 5'd0, 32'd2);
    req_valid = 1'b0;
    out_ready = 1'b0;
    word("srai", 32'h4021D193, 16'h0008);
    for (int k = 0; k < 3; k++) begin
      tick();
      word("srai_hold", 32'h4021D193, 16'h0008);
      chk("srai_hold_rdy", {31'd0, req_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("srai_drain_vld", {31'd0, out_valid}, 32'd0);

    // Illegal op: accepted, flagged, nothing emitted
    issue("ill", 6'h3F, 5'd1, 5'd1, 5'd1, 32'd0);
    req_valid = 1'b0;
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_vld", {31'd0, out_valid}, 32'd0);
    issue("nop", OP_NOP, 5'd4, 5'd4, 5'd4, 32'h7FF);
    word("nop", 32'h00000013, 16'h000C);

    // Further encodings, back-to-back
    issue("sub", OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
    word("sub", 32'h402081B3, 16'h0010);
    issue("sw", OP_SW, 5'd0, 5'd2, 5'd5, 32'd8);
    word("sw", 32'h00512423, 16'h0014);
    issue("j", OP_J, 5'd5, 5'd0, 5'd0, 32'hFFFFFFF8);
    word("j", 32'hFF9FF06F, 16'h0018);
    issue("li_m1", OP_LI, 5'd7, 5'd0, 5'd0, 32'hFFFFFFFF);
    word("li_m1", 32'hFFF00393, 16'h001C);
    issue("lui", OP_LUI, 5'd10, 5'd0, 5'd0, 32'hABCDE000);
    word("lui", 32'hABCDE537, 16'h0020);
    issue("li_4k", OP_LI, 5'd6, 5'd0, 5'd0, 32'h00001000);
    req_valid = 1'b0;
    word("li_4k_lui", 32'h00001337, 16'h0024);
    tick();
    word("li_4k_addi", 32'h00030313, 16'h0028);
    chk("err_sticky", {31'd0, err}, 32'd1);
    tick();

    // Reset in the middle of an LI expansion
    out_ready = 1'b0;
    issue("li_rst", OP_LI, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    req_valid = 1'b0;
    chk("li_rst_li2_rdy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_vld",  {31'd0, out_valid}, 32'd0);
    chk("rst2_addr", {16'd0, out_addr}, 32'd0);
    chk("rst2_err",  {31'd0, err}, 32'd0);
    chk("rst2_idle_rdy", {31'd0, req_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("rst2_no_addi", {31'd0, out_valid}, 32'd0);
    issue("nop2", OP_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
    word("nop2", 32'h00000013, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
